// File: rtl/wide_add_seq.sv
// wide_add_seq: 16-bit ADD/ADC/SUB/SBB sequenced over a shared 8-bit adder that has no carry-in.
// Carries are injected with extra "+1" passes. The optional byte mode is enabled by WIDE_ADD_BYTE_MODE_EN.
module wide_add_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cf_in,
`ifdef WIDE_ADD_BYTE_MODE_EN
    input  logic        w,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cf,
    output logic        zf,
    output logic        sf,
    output logic        of,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    input  logic [7:0]  add_sum,
    input  logic        add_cout
);
    typedef enum logic [2:0] {IDLE, LO, LO_INC, HI, HI_INC} state_t;
    state_t      r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_sub;
    logic        r_c0;
    logic        r_k;
    logic        r_c16;
    logic [7:0]  r_slo;
    logic [7:0]  r_shi;
    logic        w_byte;
    logic        w_byte_fin;
    logic        w_fin;
    logic        w_k;
    logic        w_c16;
    logic [15:0] w_res;
    logic        w_cy;
    logic        w_of;
`ifdef WIDE_ADD_BYTE_MODE_EN
    logic        r_w;
    assign w_byte = !r_w;
`else
    assign w_byte = 1'b0;
`endif
    // Route the current pass's operands to the shared adder; idle drives zeros.
    always_comb begin
        add_a = (r_state == LO) ? r_a[7:0] :
                (r_state == LO_INC) ? r_slo :
                (r_state == HI) ? r_a[15:8] :
                (r_state == HI_INC) ? r_shi : 8'h00;
        add_b = (r_state == LO) ? r_b[7:0] :
                (r_state == HI) ? r_b[15:8] :
                (r_state == LO_INC || r_state == HI_INC) ? 8'h01 : 8'h00;
    end
    // Decide whether this pass is the last one and form the final result and flags from the live adder output.
    always_comb begin
        w_byte_fin = w_byte && ((r_state == LO && !r_c0) || r_state == LO_INC);
        w_fin = w_byte_fin || (r_state == HI && !r_k) || r_state == HI_INC;
        w_k = (r_state == LO_INC) ? (r_k | add_cout) : add_cout;
        w_c16 = (r_state == HI_INC) ? (r_c16 | add_cout) : add_cout;
        w_res = w_byte_fin ? {8'h00, add_sum} : {add_sum, r_slo};
        w_cy = w_byte_fin ? w_k : w_c16;
        w_of = w_byte_fin ? ((r_a[7] == r_b[7]) && (add_sum[7] != r_a[7])) :
                            ((r_a[15] == r_b[15]) && (add_sum[7] != r_a[15]));
    end
    // Sequencer: accept a request, step through the adder passes, register result and flags on the final pass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a <= '0;
            r_b <= '0;
            r_sub <= 1'b0;
            r_c0 <= 1'b0;
            r_k <= 1'b0;
            r_c16 <= 1'b0;
            r_slo <= '0;
            r_shi <= '0;
`ifdef WIDE_ADD_BYTE_MODE_EN
            r_w <= 1'b0;
`endif
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
            cf <= 1'b0;
            zf <= 1'b0;
            sf <= 1'b0;
            of <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_a <= a;
                    r_b <= op[1] ? ~b : b;
                    r_sub <= op[1];
                    r_c0 <= op[1] ^ (op[0] & cf_in);
`ifdef WIDE_ADD_BYTE_MODE_EN
                    r_w <= w;
`endif
                    busy <= 1'b1;
                    r_state <= LO;
                end
                LO: begin
                    r_slo <= add_sum;
                    r_k <= w_k;
                    r_state <= r_c0 ? LO_INC : HI;
                end
                LO_INC: begin
                    r_slo <= add_sum;
                    r_k <= w_k;
                    r_state <= HI;
                end
                HI: begin
                    r_shi <= add_sum;
                    r_c16 <= w_c16;
                    r_state <= r_k ? HI_INC : IDLE;
                end
                HI_INC: begin
                    r_shi <= add_sum;
                    r_c16 <= w_c16;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_fin) begin
                r_state <= IDLE;
                busy <= 1'b0;
                done <= 1'b1;
                result <= w_res;
                cf <= w_cy ^ r_sub;
                zf <= (w_res == 16'h0000);
                sf <= add_sum[7];
                of <= w_of;
            end
        end
    end
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: directed self-checking bench for wide_add_seq (default word-only build).
module tb_wide_add_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cf_in = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cf;
    logic        zf;
    logic        sf;
    logic        of;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_sum;
    logic        add_cout;
    int          n_chk = 0;
    int          n_fail = 0;

    wide_add_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cf_in(cf_in),
        .busy(busy), .done(done), .result(result), .cf(cf), .zf(zf), .sf(sf), .of(of),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout)
    );

    // Plain 8-bit adder without carry-in, as seen by the sequencer.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation; optionally re-assert start with a different a during LO.
    // ef = {cf, zf, sf, of}; ep = expected number of adder passes.
    task automatic run(input string tag, input logic [1:0] o, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic ci, input bit poke, input logic [15:0] er, input logic [3:0] ef, input int ep);
        int n;
        logic [15:0] bp;
        bp = o[1] ? ~tb_ : tb_;
        @(negedge clk);
        start = 1'b1; op = o; a = ta; b = tb_; cf_in = ci;
        @(negedge clk);
        start = poke; a = poke ? 16'h5A5A : ta;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        chk({tag, ".lo_a"}, {24'd0, add_a}, {24'd0, ta[7:0]});
        chk({tag, ".lo_b"}, {24'd0, add_b}, {24'd0, bp[7:0]});
        n = 0;
        while (done !== 1'b1 && n < 8) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk({tag, ".passes"}, n, ep);
        chk({tag, ".result"}, {16'd0, result}, {16'd0, er});
        chk({tag, ".flags"}, {28'd0, cf, zf, sf, of}, {28'd0, ef});
        chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, ".done_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.result", {16'd0, result}, 32'd0);
        chk("rst.flags", {28'd0, cf, zf, sf, of}, 32'd0);
        chk("rst.adder", {16'd0, add_a, add_b}, 32'd0);
        rst_n = 1'b1;
        run("add_00ff", 2'b00, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 4'b0000, 3);
        chk("idle.adder", {16'd0, add_a, add_b}, 32'd0);
        run("add_ffff", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1100, 3);
        run("add_7fff", 2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0011, 3);
        run("sub_0_1", 2'b10, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 4'b1010, 3);
        run("sub_5_5", 2'b10, 16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0000, 4'b0100, 4);
        run("sbb", 2'b11, 16'h1234, 16'h0034, 1'b1, 1'b0, 16'h11FF, 4'b0000, 2);
        run("adc_c0", 2'b01, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 4'b0000, 2);
        run("adc_c1", 2'b01, 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 4'b1001, 3);
        run("poke", 2'b00, 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 4'b0000, 3);
        // Abort a sequence with reset while in HI.
        run("pre_rst", 2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1100, 3);
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 16'h00FF; b = 16'h0001; cf_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("hi.add_a", {24'd0, add_a}, 32'h00);
        chk("hi.add_b", {24'd0, add_b}, 32'h00);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.result", {16'd0, result}, 32'd0);
        chk("abort.flags", {28'd0, cf, zf, sf, of}, 32'd0);
        chk("abort.adder", {16'd0, add_a, add_b}, 32'd0);
        @(negedge clk);
        chk("abort.nodone", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        run("post_rst", 2'b01, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 4'b0000, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
